es_stream_decoder: RTL

- Converts NUM_INPUTS parallel stochastic bitstream lanes back to binary.
- Counts the ones on each lane over a fixed window of 2^DATA_WIDTH valid bits, then presents the counts as a packed binary word with a one-cycle done pulse.
- Sits at the output end of the deterministic stochastic datapath. It is the stream-to-binary counterpart of the binary-to-stream front end used by es_naive_mul and sibling arithmetic cores.

---
 rtl/es_stream_decoder.sv | 126 ++++++++++++
 1 files changed

// File: rtl/es_stream_decoder.sv
// es_stream_decoder: per-lane ones counter over a 2^DATA_WIDTH valid-bit window, stochastic stream to binary.
// Build option ES_DEC_SATURATE_EN: a full-window count clamps to all ones instead of wrapping to zero.

module es_dec_lane #(
    parameter int DATA_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  en,
    input  logic                  bit_in,
    output logic [DATA_WIDTH-1:0] result
);
    // One extra bit so an all-ones window (2^DATA_WIDTH) is representable.
    logic [DATA_WIDTH:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && bit_in)
            cnt <= cnt + 1'b1;
    end

`ifdef ES_DEC_SATURATE_EN
    assign result = cnt[DATA_WIDTH] ? '1 : cnt[DATA_WIDTH-1:0];
`else
    logic unused_cnt_msb;
    assign unused_cnt_msb = cnt[DATA_WIDTH];
    assign result         = cnt[DATA_WIDTH-1:0];
`endif
endmodule

module es_stream_decoder #(
    parameter int DATA_WIDTH = 5,
    parameter int NUM_INPUTS = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             bit_valid,
    input  logic [NUM_INPUTS-1:0]            sc_bits_in,
    output logic [NUM_INPUTS*DATA_WIDTH-1:0] bin_data_out,
    output logic                             busy,
    output logic                             done
);
    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    localparam logic [DATA_WIDTH:0] WIN_LAST = {1'b0, {DATA_WIDTH{1'b1}}};

    state_t                                 state, state_nxt;
    logic   [DATA_WIDTH:0]                  win_cnt;
    logic                                   cnt_clr, cnt_en, last_bit;
    logic   [NUM_INPUTS-1:0][DATA_WIDTH-1:0] lane_res;

    assign cnt_en   = (state == COUNT) && bit_valid;
    assign last_bit = cnt_en && (win_cnt == WIN_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = COUNT;
                    cnt_clr   = 1'b1;
                end
            end
            COUNT: begin
                if (last_bit)
                    state_nxt = DONE;
            end
            DONE: begin
                if (start) begin
                    state_nxt = COUNT;
                    cnt_clr   = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            win_cnt <= '0;
        else if (cnt_clr)
            win_cnt <= '0;
        else if (cnt_en)
            win_cnt <= win_cnt + 1'b1;
    end

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
        es_dec_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
            .clk    (clk),
            .rst    (rst),
            .clr    (cnt_clr),
            .en     (cnt_en),
            .bit_in (sc_bits_in[i]),
            .result (lane_res[i])
        );
    end

    // Outputs are registered off the state, so done trails DONE by one cycle and never overlaps busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy         <= 1'b0;
            done         <= 1'b0;
            bin_data_out <= '0;
        end else begin
            busy <= (state == COUNT);
            done <= (state == DONE);
            if (state == DONE)
                bin_data_out <= lane_res;
        end
    end
endmodule
